decode_stage: RTL

- Registered, handshaked instruction-decode stage for the pipelined RV32I/RV64I core. Parametrised by XLEN.
- Accepts fetched instruction+PC on a valid/ready interface and emits decoded control bundles on a second valid/ready interface.
- Uses a 2-entry skid buffer, so in_ready is a registered signal.
- Adds illegal-instruction detection, XLEN-dependent legality, flush/squash, and a sticky halt state machine. The single-cycle decoder has none of these.

---
 rtl/rv_decode_pkg.sv | 58 +++++
 rtl/rv_decode_comb.sv | 98 +++++++++
 rtl/decode_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared decode types for the pipelined RV32I/RV64I core: opcodes, control bundle
// layout, field encodings and the decode-stage FSM states.
package rv_decode_pkg;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_32      = 7'b0111011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10, MEM_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    HC_NONE = 2'b00, HC_SYSTEM = 2'b01, HC_ILLEGAL = 2'b10
  } halt_cause_e;

  typedef enum logic [1:0] {
    S_RUN = 2'b00, S_DRAIN = 2'b01, S_HALTED = 2'b10
  } state_e;

  typedef struct packed {
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        reg_write_en;
    logic        mem_write_en;
    logic        mem_read_en;
    result_src_e result_src;
    imm_src_e    imm_src;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        word_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    branch: 1'b0, jump: 1'b0, alu_src: 1'b0, reg_write_en: 1'b0,
    mem_write_en: 1'b0, mem_read_en: 1'b0, result_src: RES_ALU,
    imm_src: IMM_I, mem_size: MEM_D, mem_unsigned: 1'b0, word_op: 1'b0
  };

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational instruction decoder: control bundle, illegal flag and
// SYSTEM detection. Illegal encodings always produce the NOP bundle.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_system
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  ctrl_t      dec;
  logic       bad;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    dec = CTRL_NOP;
    bad = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec.alu_src      = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.mem_read_en  = 1'b1;
        dec.result_src   = RES_MEM;
        dec.mem_size     = mem_size_e'(funct3[1:0]);
        dec.mem_unsigned = funct3[2];
        bad = (funct3 == 3'b111) || (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110));
      end
      OP_STORE: begin
        dec.alu_src      = 1'b1;
        dec.mem_write_en = 1'b1;
        dec.imm_src      = IMM_S;
        dec.mem_size     = mem_size_e'(funct3[1:0]);
        bad = funct3[2] || (!RV64 && funct3 == 3'b011);
      end
      OP_IMM: begin
        dec.alu_src      = 1'b1;
        dec.reg_write_en = 1'b1;
      end
      OP_IMM_32: begin
        dec.alu_src      = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.word_op      = 1'b1;
        bad = !RV64;
      end
      OP_RTYPE: dec.reg_write_en = 1'b1;
      OP_32: begin
        dec.reg_write_en = 1'b1;
        dec.word_op      = 1'b1;
        bad = !RV64;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = IMM_B;
        bad = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec.jump         = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.result_src   = RES_PC4;
        dec.imm_src      = IMM_J;
      end
      OP_JALR: begin
        dec.jump         = 1'b1;
        dec.alu_src      = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.result_src   = RES_PC4;
        bad = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec.reg_write_en = 1'b1;
        dec.result_src   = RES_IMM;
        dec.imm_src      = IMM_U;
      end
      OP_AUIPC: begin
        dec.alu_src      = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.imm_src      = IMM_U;
      end
      OP_SYSTEM: dec = CTRL_NOP;
      default:   bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  assign illegal   = bad;
  assign ctrl      = bad ? CTRL_NOP : dec;
  assign is_system = !bad && (opcode == OP_SYSTEM);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer, flush support and a sticky
// halt FSM that stops intake after ECALL/EBREAK or an illegal instruction.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output ctrl_t           out_ctrl,
  output logic            out_illegal,
  output logic            halted,
  output logic [1:0]      halt_cause
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctrl_t           ctrl;
    logic            illegal;
  } entry_t;

  ctrl_t       dec_ctrl;
  logic        dec_illegal, dec_is_system;
  entry_t      in_entry, main_d, main_q, skid_d, skid_q;
  logic        main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
  logic        in_ready_d, in_ready_q;
  state_e      state_d, state_q;
  halt_cause_e halt_cause_d, halt_cause_q;
  logic        accept, xfer, halting;

  rv_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr     (in_instr),
    .ctrl      (dec_ctrl),
    .illegal   (dec_illegal),
    .is_system (dec_is_system)
  );

  assign in_entry = '{pc: in_pc, instr: in_instr, ctrl: dec_ctrl, illegal: dec_illegal};
  assign accept   = in_valid & in_ready_q;
  assign xfer     = main_valid_q & out_ready;
  assign halting  = dec_is_system | (dec_illegal & HALT_ON_ILLEGAL);

  // in_ready is only high in RUN with an empty skid entry, so an accept never lands on a full skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush && state_q != S_HALTED) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        if (accept) main_d = in_entry;
        main_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    halt_cause_d = halt_cause_q;
    case (state_q)
      S_RUN: begin
        if (!flush && accept && halting) begin
          state_d      = S_DRAIN;
          halt_cause_d = dec_is_system ? HC_SYSTEM : HC_ILLEGAL;
        end
      end
      S_DRAIN: begin
        if (flush) begin
          state_d      = S_RUN;
          halt_cause_d = HC_NONE;
        end else if (!main_valid_d && !skid_valid_d) begin
          state_d = S_HALTED;
        end
      end
      default: state_d = state_q;
    endcase
    in_ready_d = (state_d == S_RUN) && !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      state_q      <= S_RUN;
      halt_cause_q <= HC_NONE;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_pc      = main_q.pc;
  assign out_instr   = main_q.instr;
  assign out_ctrl    = main_q.ctrl;
  assign out_illegal = main_q.illegal;
  assign halted      = (state_q == S_HALTED);
  assign halt_cause  = halt_cause_q;

endmodule
